keypad_matrix: RTL and testbench
================================

# keypad_matrix

Scans the 4×4 calculator keypad, debounces it and hands one key code per press to the command decoder through a valid/ack handshake. It sits directly upstream of the key-to-command stage that feeds `CPU`. It drives the keypad column strobes, samples the row returns and reports clean press events. Release events and ghosted multi-key frames are never reported.

## Interface
- `SCAN_DIV`, 1000: clock cycles each column stays driven (≥2).
- `DEBOUNCE`, 4: consecutive identical frames required to accept a press or a release (≥1).
- `Clock`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `row_in`  in  4  keypad row returns; active-low with external pull-ups.
- `col_out`  out  4  column strobes; one-cold, active-low.
- `key_code`  out  4  accepted key, `{col[1:0], row[1:0]}`.
- `key_valid`  out  1  `key_code` holds an unconsumed press.
- `key_ack`  in  1  consumer takes the key when `key_valid && key_ack`.
- `overrun`  out  1  one-cycle pulse: press accepted while the buffer was full; that press is dropped.

## Operation
- **Scan**
  - A dwell counter counts 0..`SCAN_DIV`-1.
  - A column index `c` advances 0→1→2→3→0 when the dwell counter wraps.
  - `col_out` = ~(1<<c).
  - `row_in` is sampled only in the last dwell cycle (`SCAN_DIV`-1), so settling is ≥`SCAN_DIV`-1 cycles.
- **Frame**
  - The four column samples are accumulated into a frame.
  - The frame closes on the sample cycle of column 3.
  - Frame class:
    - NONE: no row low in any column.
    - ONE(code): exactly one low bit across all 16 positions; code = `{c, r}`.
    - MULTI: more than one low bit.
- **Debounce FSM**, evaluated once per closed frame:
  - IDLE
    - ONE(k) → CAND, cand=k, cnt=1. If `DEBOUNCE`=1, go straight to PRESSED and accept.
    - NONE or MULTI → stay.
  - CAND
    - ONE(cand): cnt+1. When cnt reaches `DEBOUNCE` → PRESSED and accept cand.
    - ONE(other) → restart CAND with the new code, cnt=1.
    - NONE or MULTI → IDLE.
  - PRESSED
    - NONE → REL, cnt=1; if `DEBOUNCE`=1, go to IDLE.
    - Anything else → stay. No auto-repeat; a second key while held is ignored.
  - REL
    - NONE: cnt+1. When cnt reaches `DEBOUNCE` → IDLE.
    - Anything else → PRESSED.
  - cnt is ceil(log2(`DEBOUNCE`+1)) bits wide and never exceeds `DEBOUNCE`.
- **Output buffer** (one entry)
  - Accept with `key_valid`=0: `key_code`←cand, `key_valid`←1.
  - Accept with `key_valid`=1: `key_code` unchanged, `overrun` pulses.
  - Ack with no accept in the same cycle: `key_valid`←0, `key_code` holds its value.
  - Ack and accept in the same cycle: the new key loads, `key_valid` stays 1, no overrun.
  - `key_ack` while `key_valid`=0 is ignored.

## Timing
- **Reset values:** `col_out`=4'b1110, `key_code`=0, `key_valid`=0, `overrun`=0. FSM=IDLE, `c`=0, dwell=0, frame cleared. Reset takes effect immediately, including mid-frame or mid-debounce.
- **Frame period:** 4·`SCAN_DIV` cycles. The first frame closes at cycle 4·`SCAN_DIV`-1 after reset release.
- **Press latency:** `key_valid` rises the cycle after the sample cycle of the `DEBOUNCE`-th consecutive matching frame.
  - Worst case from a stable press: (`DEBOUNCE`+1)·4·`SCAN_DIV` cycles.
- **Release to next press:** the earliest next accept needs `DEBOUNCE` NONE frames followed by `DEBOUNCE` ONE frames.
- **Registered outputs:** all outputs are registered. `overrun` is high for exactly one cycle, the cycle after the sample edge that accepted the dropped press.
- **Column change:** `col_out` changes on the cycle after the dwell wrap.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE`=3.
- **Reset:** hold `Reset`=0, then release.
  - `col_out` sequence: 1110 ×4 cycles, 1101, 1011, 0111, repeating every 16 cycles.
  - `key_valid`=0 throughout with `row_in`=1111.
- **Clean press:** key col2/row1 (`row_in`[1]=0 only while `col_out`=1011), held 10 frames.
  - `key_valid`=1 and `key_code`=4'b1001 exactly one cycle after the 3rd frame close (cycle 48 after press start, press aligned to a frame).
  - Exactly one event for the whole hold.
- **Bounce:** press toggles each frame (ONE, NONE, ONE, NONE…) for 8 frames, then holds stable.
  - No `key_valid` during bouncing; accept occurs 3 frames into the stable hold.
- **Ghosting:** two keys pressed together for 10 frames → no event.
  - Then release one: accept of the remaining key after 3 frames.
- **Overrun:** `key_ack` held 0; press and release key 5, then press key 7.
  - `key_code`=5 stays; `overrun` pulses once at key 7's accept.
  - Raising `key_ack` clears `key_valid` on the next cycle.
- **Ack/accept collision:** assert `key_ack` exactly on key 7's accept cycle with key 5 pending.
  - `key_code`=7, `key_valid` stays 1, `overrun`=0.
  - Asserting `Reset` mid-CAND returns all outputs to reset values immediately.

Source files
------------

// File: rtl/keypad_matrix_if.sv
// keypad_matrix_if
// Carries accepted key presses from the keypad scanner to the command decoder.
//   key_code  : accepted key, {col[1:0], row[1:0]}
//   key_valid : key_code holds a press the consumer has not taken yet
//   key_ack   : consumer takes the key when key_valid && key_ack
//   overrun   : one-cycle pulse, a press was dropped because the buffer was full
// The scanner uses the master modport; the consumer uses the slave modport.
interface keypad_matrix_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       overrun;

  modport master (
    output key_code,
    output key_valid,
    output overrun,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  overrun,
    output key_ack
  );
endinterface

// File: rtl/keypad_matrix.sv
// keypad_matrix
// Scans a 4x4 keypad one column at a time, builds a 16-position frame every
// four columns, debounces single-key frames and hands one code per press to
// the consumer through a one-entry valid/ack buffer. Releases and ghosted
// (multi-key) frames never produce an event.
//   clk      : system clock
//   rst_n    : asynchronous, active-low reset
//   row_in   : row returns, active-low (external pull-ups)
//   col_out  : column strobes, one-cold, active-low
//   key_bus  : master side of the key handshake (key_code, key_valid,
//              key_ack, overrun)
// Parameters:
//   SCAN_DIV : cycles each column stays driven (>= 2)
//   DEBOUNCE : identical consecutive frames needed to accept a press or a
//              release (>= 1)
module keypad_matrix #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  keypad_matrix_if.master  key_bus
);

  localparam int DW    = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAND,
    S_PRESSED,
    S_REL
  } state_t;

  logic [DW-1:0]    dwell;
  logic [1:0]       col;
  logic             sample;
  logic             frame_close;

  logic [3:0]       row_low;
  logic [2:0]       col_hits;
  logic [1:0]       col_row;

  // Frame accumulator: hit count saturates at 2 (meaning "more than one").
  logic [1:0]       hit_cnt;
  logic [3:0]       hit_code;
  logic [2:0]       hit_sum;
  logic [1:0]       frame_cnt;
  logic [3:0]       frame_code;
  logic             frame_none;
  logic             frame_one;

  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  logic [3:0]       code_q;
  logic             valid_q;
  logic             overrun_q;

  // Rows are only trusted on the last dwell cycle of a column, which gives
  // the keypad lines SCAN_DIV-1 cycles to settle after the strobe moves.
  assign sample      = (dwell == DW'(SCAN_DIV - 1));
  assign frame_close = sample && (col == 2'd3);

  // Dwell counter and column rotation; col_out is kept as its own register
  // so the strobe pins come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      col     <= 2'd0;
      col_out <= 4'b1110;
    end else if (sample) begin
      dwell   <= '0;
      col     <= col + 2'd1;
      col_out <= {col_out[2:0], col_out[3]};
    end else begin
      dwell   <= dwell + DW'(1);
    end
  end

  // Count low rows in the current column and remember which row was low.
  assign row_low = ~row_in;

  always_comb begin
    col_hits = 3'd0;
    col_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (row_low[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
  end

  // Merge this column into the running frame. The code is only meaningful
  // when the merged count is exactly one.
  always_comb begin
    hit_sum    = {1'b0, hit_cnt} + col_hits;
    frame_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_code = (col_hits == 3'd1) ? {col, col_row} : hit_code;
  end

  assign frame_none = (frame_cnt == 2'd0);
  assign frame_one  = (frame_cnt == 2'd1);

  // Accumulator is cleared when the frame closes so the next frame starts
  // empty at column 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= 2'd0;
      hit_code <= 4'd0;
    end else if (sample) begin
      if (col == 2'd3) begin
        hit_cnt  <= 2'd0;
        hit_code <= 4'd0;
      end else begin
        hit_cnt  <= frame_cnt;
        hit_code <= frame_code;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce next state, evaluated only on the cycle a frame closes. While a
  // key is held every non-empty frame (including ghosted ones) keeps the
  // press alive, so a second key can never generate an event.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (frame_close) begin
      case (state_q)
        S_IDLE: begin
          if (frame_one) begin
            cand_d = frame_code;
            cnt_d  = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              state_d = S_PRESSED;
              accept  = 1'b1;
            end else begin
              state_d = S_CAND;
            end
          end
        end
        S_CAND: begin
          if (frame_one) begin
            if (frame_code == cand_q) begin
              if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                state_d = S_PRESSED;
                accept  = 1'b1;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end else begin
              cand_d = frame_code;
              cnt_d  = CNT_W'(1);
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (frame_none) begin
            cnt_d   = CNT_W'(1);
            state_d = (DEBOUNCE == 1) ? S_IDLE : S_REL;
          end
        end
        S_REL: begin
          if (frame_none) begin
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = S_PRESSED;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // One-entry output buffer. An ack in the same cycle as an accept frees the
  // slot just in time, so the new key loads instead of overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (accept) begin
        if (valid_q && !key_bus.key_ack) begin
          overrun_q <= 1'b1;
        end else begin
          code_q  <= frame_code;
          valid_q <= 1'b1;
        end
      end else if (key_bus.key_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign key_bus.key_code  = code_q;
  assign key_bus.key_valid = valid_q;
  assign key_bus.overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_matrix.sv
// tb_keypad_matrix
// Drives keypad_matrix through a simulated 4x4 key switch matrix, keeps a
// behavioural model of scan, frame classification, debounce and buffer, and
// compares every output on every cycle, plus directed literal expectations.
module tb_keypad_matrix;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FRAME = 4 * SD;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] key_mask;
  logic        key_ack;
  logic        check_en;

  int n_vec;
  int n_err;
  int cyc;

  keypad_matrix_if key_bus ();

  assign key_bus.key_ack = key_ack;

  keypad_matrix #(
    .SCAN_DIV (SD),
    .DEBOUNCE (DB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .row_in  (row_in),
    .col_out (col_out),
    .key_bus (key_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Switch matrix: a closed key at (c, r) pulls row r low while column c is
  // strobed low.
  always_comb begin
    row_in = 4'hF;
    for (int j = 0; j < 4; j++)
      for (int r = 0; r < 4; r++)
        if (key_mask[j*4 + r] && !col_out[j]) row_in[r] = 1'b0;
  end

  // Cycles since reset release, for aligning presses to frames.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_dwell;
  int          m_col;
  logic [15:0] m_frame;
  bit          m_held;
  int          m_run_len;
  int          m_run_code;
  int          m_none_run;
  logic        m_valid;
  logic [3:0]  m_code;
  logic        m_ovr;

  always @(posedge clk or negedge rst_n) begin
    bit accept;
    int nlow;
    int pos;
    if (!rst_n) begin
      m_dwell = 0; m_col = 0; m_frame = '0;
      m_held = 0; m_run_len = 0; m_run_code = 0; m_none_run = 0;
      m_valid = 0; m_code = 0; m_ovr = 0;
    end else begin
      accept = 0;
      if (m_dwell == SD - 1) begin
        for (int r = 0; r < 4; r++)
          if (key_mask[m_col*4 + r]) m_frame[m_col*4 + r] = 1'b1;
        if (m_col == 3) begin
          nlow = $countones(m_frame);
          pos = 0;
          for (int i = 0; i < 16; i++) if (m_frame[i]) pos = i;
          if (!m_held) begin
            if (nlow == 1) begin
              m_run_len  = (m_run_len > 0 && pos == m_run_code) ? m_run_len + 1 : 1;
              m_run_code = pos;
              if (m_run_len == DB) begin
                accept = 1; m_held = 1; m_none_run = 0; m_run_len = 0;
              end
            end else begin
              m_run_len = 0;
            end
          end else begin
            if (nlow == 0) begin
              m_none_run++;
              if (m_none_run == DB) begin m_held = 0; m_run_len = 0; end
            end else begin
              m_none_run = 0;
            end
          end
          m_frame = '0;
        end
      end
      m_ovr = 0;
      if (accept) begin
        if (m_valid && !key_ack) m_ovr = 1;
        else begin m_code = 4'(m_run_code); m_valid = 1; end
      end else if (key_ack) begin
        m_valid = 0;
      end
      if (m_dwell == SD - 1) begin
        m_dwell = 0;
        m_col = (m_col + 1) % 4;
      end else begin
        m_dwell++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] exp_col;
    if (check_en) begin
      exp_col = ~(4'b0001 << m_col);
      checkOutput("col_out",   col_out,           exp_col);
      checkOutput("key_valid", key_bus.key_valid, m_valid);
      checkOutput("key_code",  key_bus.key_code,  m_code);
      checkOutput("overrun",   key_bus.overrun,   m_ovr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic settle();
    key_mask = '0;
    key_ack  = 1'b0;
    repeat (80) @(negedge clk);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic align_frame();
    int guard;
    guard = 0;
    while ((cyc % FRAME) != 0 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Runs ncyc cycles, pinning key_valid low just before 'at' and high with
  // the given code at 'at', and counts key_valid rising edges.
  task automatic run_window(input string name, input int ncyc, input int at,
                            input logic [3:0] code, output int rises);
    logic prev;
    rises = 0;
    prev  = key_bus.key_valid;
    for (int n = 0; n < ncyc; n++) begin
      if (n == at - 1) checkOutput({name, "_early"}, key_bus.key_valid, 1'b0);
      if (n == at) begin
        checkOutput({name, "_valid"}, key_bus.key_valid, 1'b1);
        checkOutput({name, "_code"},  key_bus.key_code,  code);
      end
      if (key_bus.key_valid && !prev) rises++;
      prev = key_bus.key_valid;
      @(negedge clk);
    end
  endtask

  task automatic quiet_window(input int ncyc, output int any_valid);
    any_valid = 0;
    for (int n = 0; n < ncyc; n++) begin
      if (key_bus.key_valid) any_valid = 1;
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input int dur);
    key_mask = mask;
    for (int n = 0; n < dur; n++) begin
      key_ack = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    key_ack = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [3:0] col_seq [4];
    int rises;
    int anyv;
    int pulses;
    logic [15:0] mask;
    int k1, k2, sel;

    col_seq[0] = 4'b1110; col_seq[1] = 4'b1101;
    col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;
    n_vec = 0; n_err = 0;
    check_en = 1'b0;
    rst_n    = 1'b0;
    key_mask = '0;
    key_ack  = 1'b0;

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    checkOutput("rst_col_out", col_out, 4'b1110);
    checkOutput("rst_valid",   key_bus.key_valid, 1'b0);
    checkOutput("rst_code",    key_bus.key_code, 4'd0);
    checkOutput("rst_overrun", key_bus.overrun, 1'b0);

    // Column sequence after release
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      checkOutput("col_seq", col_out, col_seq[(i / SD) % 4]);
      checkOutput("idle_valid", key_bus.key_valid, 1'b0);
      @(negedge clk);
    end

    // Clean press of col2/row1 held 10 frames: one event, code 1001
    settle();
    align_frame();
    key_mask = 16'(1) << 9;
    run_window("clean", 10 * FRAME, 48, 4'b1001, rises);
    checkOutput("clean_events", rises, 1);

    // Bounce: alternating ONE/NONE frames, then stable hold
    settle();
    align_frame();
    anyv = 0;
    for (int f = 0; f < 8; f++) begin
      key_mask = (f % 2 == 0) ? (16'(1) << 6) : 16'h0;
      quiet_window(FRAME, rises);
      if (rises != 0) anyv = 1;
    end
    checkOutput("bounce_quiet", anyv, 0);
    key_mask = 16'(1) << 6;
    run_window("bounce", 4 * FRAME, 48, 4'd6, rises);

    // Ghosting: two keys give nothing; releasing one accepts the other
    settle();
    align_frame();
    key_mask = (16'(1) << 1) | (16'(1) << 14);
    quiet_window(10 * FRAME, anyv);
    checkOutput("ghost_quiet", anyv, 0);
    key_mask = 16'(1) << 1;
    run_window("ghost", 4 * FRAME, 48, 4'd1, rises);

    // Overrun: key 5 pending, key 7 accepted and dropped
    settle();
    align_frame();
    key_mask = 16'(1) << 5;
    repeat (4 * FRAME) @(negedge clk);
    key_mask = '0;
    repeat (4 * FRAME) @(negedge clk);
    key_mask = 16'(1) << 7;
    pulses = 0;
    for (int n = 0; n < 4 * FRAME; n++) begin
      if (n == 47) checkOutput("ovr_early", key_bus.overrun, 1'b0);
      if (n == 48) begin
        checkOutput("ovr_pulse", key_bus.overrun, 1'b1);
        checkOutput("ovr_code",  key_bus.key_code, 4'd5);
        checkOutput("ovr_valid", key_bus.key_valid, 1'b1);
      end
      if (key_bus.overrun) pulses++;
      @(negedge clk);
    end
    checkOutput("ovr_count", pulses, 1);
    key_mask = '0;
    key_ack  = 1'b1;
    @(negedge clk);
    key_ack  = 1'b0;
    checkOutput("ack_clears", key_bus.key_valid, 1'b0);

    // Ack and accept collide: key 7 loads, no overrun
    settle();
    align_frame();
    key_mask = 16'(1) << 5;
    repeat (4 * FRAME) @(negedge clk);
    key_mask = '0;
    repeat (4 * FRAME) @(negedge clk);
    key_mask = 16'(1) << 7;
    for (int n = 0; n < 4 * FRAME; n++) begin
      if (n == 47) key_ack = 1'b1;
      if (n == 48) begin
        checkOutput("coll_code",  key_bus.key_code, 4'd7);
        checkOutput("coll_valid", key_bus.key_valid, 1'b1);
        checkOutput("coll_ovr",   key_bus.overrun, 1'b0);
        key_ack = 1'b0;
      end
      @(negedge clk);
    end

    // Reset in the middle of a candidate, with key 7 still pending
    key_mask = '0;
    repeat (4 * FRAME) @(negedge clk);
    align_frame();
    key_mask = 16'(1) << 3;
    repeat (FRAME + 4) @(negedge clk);
    checkOutput("pre_rst_valid", key_bus.key_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_col",   col_out, 4'b1110);
    checkOutput("midrst_valid", key_bus.key_valid, 1'b0);
    checkOutput("midrst_code",  key_bus.key_code, 4'd0);
    checkOutput("midrst_ovr",   key_bus.overrun, 1'b0);
    key_mask = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random key activity with random acks, checked by the model
    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 99);
      k1  = $urandom_range(0, 15);
      k2  = (k1 + $urandom_range(1, 15)) % 16;
      if (sel < 40)      mask = '0;
      else if (sel < 85) mask = 16'(1) << k1;
      else               mask = (16'(1) << k1) | (16'(1) << k2);
      applyStimulus(mask, $urandom_range(16, 200));
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
